if_fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register, directly downstream of the control-hazard bubble generator. Owns the PC. Consumes the 2-bit bubble counts for jump/branch and for eret/syscall, plus redirect targets from later stages and a load-use stall. Presents the fetch address to instruction memory and registers instruction/PC into IF/ID, injecting NOPs while bubbles are pending.

---
 rtl/if_fetch_stage.sv | 122 ++++++++++++
 tb/tb_if_fetch_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives combinational instruction memory,
// and loads the IF/ID register, injecting NOPs on redirects and pending bubbles.
module if_fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       bubble,
    input  logic [1:0]       bubble_noblock,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             exc_valid,
    input  logic [31:0]      exc_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             fetch_misalign,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [2:0] {
        ACT_EXC,
        ACT_REDIRECT,
        ACT_STALL,
        ACT_BUBBLE,
        ACT_FETCH
    } action_t;

    logic [31:0]      pc_reg;
    logic [31:0]      pc_next;
    logic [31:0]      pc_plus4;
    logic [31:0]      if_id_instr_reg;
    logic [31:0]      if_id_pc_reg;
    logic [31:0]      if_id_pc4_reg;
    logic             if_id_valid_reg;
    logic             fetch_misalign_reg;
    logic [CNT_W-1:0] fetch_cnt_reg;
    logic [CNT_W-1:0] bubble_cnt_reg;
    logic             bubble_pending;
    action_t          action;

    assign pc_plus4       = pc_reg + 32'd4;
    assign bubble_pending = (bubble != 2'd0) || (bubble_noblock != 2'd0);

    // Single priority decode shared by the PC and IF/ID update paths.
    always_comb begin
        if (exc_valid)
            action = ACT_EXC;
        else if (redirect_valid)
            action = ACT_REDIRECT;
        else if (stall)
            action = ACT_STALL;
        else if (bubble_pending)
            action = ACT_BUBBLE;
        else
            action = ACT_FETCH;
    end

    always_comb begin
        pc_next = pc_reg;
        case (action)
            ACT_EXC:      pc_next = exc_pc;
            ACT_REDIRECT: pc_next = redirect_pc;
            ACT_FETCH:    pc_next = pc_plus4;
            default:      pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg             <= PC_RESET;
            fetch_misalign_reg <= 1'b0;
            if_id_instr_reg    <= NOP_INSTR;
            if_id_pc_reg       <= 32'd0;
            if_id_pc4_reg      <= 32'd0;
            if_id_valid_reg    <= 1'b0;
            fetch_cnt_reg      <= '0;
            bubble_cnt_reg     <= '0;
        end else begin
            // Misalignment tracks the PC register, so it holds whenever the PC holds.
            pc_reg             <= pc_next;
            fetch_misalign_reg <= (pc_next[1:0] != 2'b00);
            case (action)
                ACT_EXC, ACT_REDIRECT: begin
                    if_id_instr_reg <= NOP_INSTR;
                    if_id_valid_reg <= 1'b0;
                end
                ACT_BUBBLE: begin
                    if_id_instr_reg <= NOP_INSTR;
                    if_id_valid_reg <= 1'b0;
                    bubble_cnt_reg  <= bubble_cnt_reg + 1'b1;
                end
                ACT_FETCH: begin
                    if_id_instr_reg <= imem_rdata;
                    if_id_pc_reg    <= pc_reg;
                    if_id_pc4_reg   <= pc_plus4;
                    if_id_valid_reg <= 1'b1;
                    fetch_cnt_reg   <= fetch_cnt_reg + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr      = pc_reg;
    assign if_id_instr    = if_id_instr_reg;
    assign if_id_pc       = if_id_pc_reg;
    assign if_id_pc4      = if_id_pc4_reg;
    assign if_id_valid    = if_id_valid_reg;
    assign fetch_misalign = fetch_misalign_reg;
    assign fetch_cnt      = fetch_cnt_reg;
    assign bubble_cnt     = bubble_cnt_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  bubble;
    logic [1:0]  bubble_noblock;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_misalign;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .bubble         (bubble),
        .bubble_noblock (bubble_noblock),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_valid      (exc_valid),
        .exc_pc         (exc_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .fetch_misalign (fetch_misalign),
        .fetch_cnt      (fetch_cnt),
        .bubble_cnt     (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] word, input logic [31:0] exp_pc, input string tag);
        imem_rdata = word;
        step();
        chk({tag, "_instr"}, if_id_instr, word);
        chk({tag, "_pc"}, if_id_pc, exp_pc);
        chk({tag, "_pc4"}, if_id_pc4, exp_pc + 32'd4);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
        $display("fetch %s: pc=%h instr=%h fetch_cnt=%0d", tag, if_id_pc, if_id_instr, fetch_cnt);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        bubble = 2'd0;
        bubble_noblock = 2'd0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        exc_valid = 1'b0;
        exc_pc = 32'd0;
        imem_rdata = 32'hDEAD_BEEF;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", imem_addr, 32'h0000_3000);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_fcnt", fetch_cnt, 32'd0);
        chk("rst_bcnt", bubble_cnt, 32'd0);
        chk("rst_mis", {31'd0, fetch_misalign}, 32'd0);
        $display("reset: addr=%h", imem_addr);
        rst = 1'b0;

        // Four free-running fetches
        fetch(32'h11, 32'h3000, "f0");
        fetch(32'h22, 32'h3004, "f1");
        fetch(32'h33, 32'h3008, "f2");
        fetch(32'h44, 32'h300C, "f3");
        chk("free_fcnt", fetch_cnt, 32'd4);
        chk("free_bcnt", bubble_cnt, 32'd0);
        chk("free_addr", imem_addr, 32'h3010);

        // Bubble window 3,2,1 then resume
        for (int i = 3; i >= 1; i--) begin
            bubble = 2'(i);
            step();
            chk("bub_valid", {31'd0, if_id_valid}, 32'd0);
            chk("bub_instr", if_id_instr, 32'h0);
            chk("bub_addr", imem_addr, 32'h3010);
            $display("bubble=%0d: addr=%h bubble_cnt=%0d", i, imem_addr, bubble_cnt);
        end
        chk("bub_bcnt", bubble_cnt, 32'd3);
        bubble = 2'd0;
        fetch(32'h55, 32'h3010, "f4");
        chk("bub_fcnt", fetch_cnt, 32'd5);
        chk("bub_addr_after", imem_addr, 32'h3014);

        // Redirect coinciding with a bubble, then a remaining bubble cycle
        redirect_valid = 1'b1;
        redirect_pc = 32'h3100;
        bubble = 2'd2;
        step();
        chk("rd_addr", imem_addr, 32'h3100);
        chk("rd_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rd_bcnt", bubble_cnt, 32'd3);
        chk("rd_fcnt", fetch_cnt, 32'd5);
        redirect_valid = 1'b0;
        bubble = 2'd1;
        step();
        chk("rdb_addr", imem_addr, 32'h3100);
        chk("rdb_bcnt", bubble_cnt, 32'd4);
        chk("rdb_valid", {31'd0, if_id_valid}, 32'd0);
        $display("redirect: addr=%h bubble_cnt=%0d", imem_addr, bubble_cnt);
        bubble = 2'd0;

        // Exception beats redirect
        exc_valid = 1'b1;
        exc_pc = 32'h4180;
        redirect_valid = 1'b1;
        redirect_pc = 32'h3200;
        step();
        chk("exc_addr", imem_addr, 32'h4180);
        chk("exc_valid", {31'd0, if_id_valid}, 32'd0);
        chk("exc_instr", if_id_instr, 32'h0);
        chk("exc_fcnt", fetch_cnt, 32'd5);
        $display("exc: addr=%h fetch_cnt=%0d", imem_addr, fetch_cnt);
        exc_valid = 1'b0;
        redirect_valid = 1'b0;

        // Stall masks pending eret/syscall bubbles
        fetch(32'h66, 32'h4180, "f5");
        stall = 1'b1;
        bubble_noblock = 2'd3;
        imem_rdata = 32'h99;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("st_addr", imem_addr, 32'h4184);
            chk("st_instr", if_id_instr, 32'h66);
            chk("st_valid", {31'd0, if_id_valid}, 32'd1);
            chk("st_pc", if_id_pc, 32'h4180);
            chk("st_fcnt", fetch_cnt, 32'd6);
            chk("st_bcnt", bubble_cnt, 32'd4);
            $display("stall %0d: addr=%h", i, imem_addr);
        end
        stall = 1'b0;
        step();
        chk("stb_valid", {31'd0, if_id_valid}, 32'd0);
        chk("stb_bcnt", bubble_cnt, 32'd5);
        chk("stb_addr", imem_addr, 32'h4184);
        $display("post-stall bubble: bubble_cnt=%0d", bubble_cnt);
        bubble_noblock = 2'd0;

        // Misaligned target
        redirect_valid = 1'b1;
        redirect_pc = 32'h3002;
        step();
        redirect_valid = 1'b0;
        chk("mis_flag", {31'd0, fetch_misalign}, 32'd1);
        chk("mis_addr", imem_addr, 32'h3002);
        fetch(32'h77, 32'h3002, "f6");
        chk("mis_addr2", imem_addr, 32'h3006);
        chk("mis_flag2", {31'd0, fetch_misalign}, 32'd1);

        // PC wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_mis", {31'd0, fetch_misalign}, 32'd0);
        fetch(32'h88, 32'hFFFF_FFFC, "f7");
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_fcnt", fetch_cnt, 32'd8);

        // Asynchronous reset mid-bubble, between clock edges
        bubble = 2'd2;
        step();
        chk("pre_rst_bcnt", bubble_cnt, 32'd6);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_addr", imem_addr, 32'h3000);
        chk("arst_instr", if_id_instr, 32'h0);
        chk("arst_pc", if_id_pc, 32'h0);
        chk("arst_pc4", if_id_pc4, 32'h0);
        chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("arst_mis", {31'd0, fetch_misalign}, 32'd0);
        chk("arst_fcnt", fetch_cnt, 32'd0);
        chk("arst_bcnt", bubble_cnt, 32'd0);
        $display("async reset: addr=%h", imem_addr);
        bubble = 2'd0;
        step();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
